computie_bus_mailbox: RTL

- Device-side register block that sits directly downstream of the bus receiver.
- Consumes the receiver's latched address, write data and data-phase qualifiers, and returns read data plus a wait/stall indication.
- Exposes a small register map: STATUS, TX_DATA, RX_DATA and SCRATCH.
- TX_DATA and RX_DATA are backed by two FIFOs with valid/ready streams toward internal logic, e.g. a UART or CPU-side peer.

---
 rtl/computie_bus_mailbox_pkg.sv | 26 ++
 rtl/computie_bus_fifo.sv | 55 +++++
 rtl/computie_bus_mailbox.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/computie_bus_mailbox_pkg.sv
// Shared constants for the bus mailbox: register offsets, STATUS bit layout
// and the bus-side state encoding.
package computie_bus_mailbox_pkg;

   localparam int REG_STATUS  = 0;
   localparam int REG_TX      = 1;
   localparam int REG_RX      = 2;
   localparam int REG_SCRATCH = 3;
   localparam int REG_IRQ_EN  = 4;

   localparam int ST_TX_FULL      = 0;
   localparam int ST_TX_EMPTY     = 1;
   localparam int ST_RX_FULL      = 2;
   localparam int ST_RX_EMPTY     = 3;
   localparam int ST_IRQ          = 4;
   localparam int ST_TX_COUNT_LSB = 8;
   localparam int ST_RX_COUNT_LSB = 16;
   localparam int ST_COUNT_W      = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_STALL = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/computie_bus_fifo.sv
// Small synchronous FIFO with occupancy count; head is valid whenever the
// FIFO is not empty. Push on full and pop on empty are ignored.
module computie_bus_fifo #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      head,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_reg;
   logic [DEPTH_LOG2-1:0] rd_ptr_reg;
   logic [DEPTH_LOG2:0]   count_reg;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count_reg == (DEPTH_LOG2 + 1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr_reg];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage needs no reset: contents are only observed through count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

endmodule

// File: rtl/computie_bus_mailbox.sv
// Bus-side mailbox register block with TX/RX FIFOs toward internal logic.
// Optional interrupt output and IRQ_ENABLE register via COMPUTIE_MAILBOX_IRQ_EN.
module computie_bus_mailbox
   import computie_bus_mailbox_pkg::*;
#(
   parameter int BITWIDTH        = 32,
   parameter int DEVICE_SIG_BITS = 8,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic                comm_clock,
   input  logic                cb_reset,
   input  logic                bus_req,
   input  logic                bus_rw,
   input  logic [BITWIDTH-1:0] bus_addr,
   input  logic [BITWIDTH-1:0] bus_wdata,
   output logic [BITWIDTH-1:0] bus_rdata,
   output logic                bus_wait,
   output logic                tx_valid,
   output logic [BITWIDTH-1:0] tx_data,
   input  logic                tx_ready,
   input  logic                rx_valid,
   input  logic [BITWIDTH-1:0] rx_data,
   output logic                rx_ready
`ifdef COMPUTIE_MAILBOX_IRQ_EN
   ,
   output logic                irq
`endif
);

   localparam int OFF_W = DEVICE_SIG_BITS - 2;
   localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;

   state_t              state_reg;
   logic [BITWIDTH-1:0] rdata_reg;
   logic [BITWIDTH-1:0] scratch_reg;
   logic [BITWIDTH-1:0] status;
   logic [BITWIDTH-1:0] read_value;
   logic [OFF_W-1:0]    offset;

   logic                tx_full, tx_empty, tx_push;
   logic                rx_full, rx_empty, rx_pop;
   logic [CNT_W-1:0]    tx_count, rx_count;
   logic [BITWIDTH-1:0] rx_head;

   logic                is_tx_write, is_rx_read, can_do, do_access;
   logic                unused_addr_bits;

   assign offset           = bus_addr[DEVICE_SIG_BITS-1:2];
   assign unused_addr_bits = &{1'b0, bus_addr[BITWIDTH-1:DEVICE_SIG_BITS], bus_addr[1:0]};

   assign is_tx_write = !bus_rw && (offset == OFF_W'(REG_TX));
   assign is_rx_read  =  bus_rw && (offset == OFF_W'(REG_RX));
   // Full/empty come from registered counts, so a same-cycle pop never frees a slot.
   assign can_do      = !(is_tx_write && tx_full) && !(is_rx_read && rx_empty);
   assign do_access   = bus_req && can_do && (state_reg == S_IDLE || state_reg == S_STALL);
   assign tx_push     = do_access && is_tx_write;
   assign rx_pop      = do_access && is_rx_read;

   assign bus_wait  = (state_reg == S_IDLE && bus_req) || (state_reg == S_STALL);
   assign bus_rdata = rdata_reg;
   assign tx_valid  = !tx_empty;
   assign rx_ready  = !rx_full;

`ifdef COMPUTIE_MAILBOX_IRQ_EN
   logic [1:0] irq_en_reg;
   logic       irq_reg;
   assign irq = irq_reg;
`endif

   always_comb begin
      status                                    = '0;
      status[ST_TX_FULL]                        = tx_full;
      status[ST_TX_EMPTY]                       = tx_empty;
      status[ST_RX_FULL]                        = rx_full;
      status[ST_RX_EMPTY]                       = rx_empty;
      status[ST_TX_COUNT_LSB +: ST_COUNT_W]     = ST_COUNT_W'(tx_count);
      status[ST_RX_COUNT_LSB +: ST_COUNT_W]     = ST_COUNT_W'(rx_count);
`ifdef COMPUTIE_MAILBOX_IRQ_EN
      status[ST_IRQ]                            = irq_reg;
`endif
   end

   always_comb begin
      read_value = '0;
      if (offset == OFF_W'(REG_STATUS))       read_value = status;
      else if (offset == OFF_W'(REG_RX))      read_value = rx_head;
      else if (offset == OFF_W'(REG_SCRATCH)) read_value = scratch_reg;
`ifdef COMPUTIE_MAILBOX_IRQ_EN
      else if (offset == OFF_W'(REG_IRQ_EN))  read_value = BITWIDTH'(irq_en_reg);
`endif
   end

   always_ff @(posedge comm_clock or posedge cb_reset) begin
      if (cb_reset) begin
         state_reg   <= S_IDLE;
         rdata_reg   <= '0;
         scratch_reg <= '0;
      end else begin
         if (do_access && bus_rw) rdata_reg <= read_value;
         if (do_access && !bus_rw && offset == OFF_W'(REG_SCRATCH)) scratch_reg <= bus_wdata;
         case (state_reg)
            S_IDLE:  if (bus_req) state_reg <= can_do ? S_DONE : S_STALL;
            S_STALL: begin
               if (!bus_req)    state_reg <= S_IDLE;
               else if (can_do) state_reg <= S_DONE;
            end
            S_DONE:  if (!bus_req) state_reg <= S_IDLE;
            default: state_reg <= S_IDLE;
         endcase
      end
   end

`ifdef COMPUTIE_MAILBOX_IRQ_EN
   always_ff @(posedge comm_clock or posedge cb_reset) begin
      if (cb_reset) begin
         irq_en_reg <= '0;
         irq_reg    <= 1'b0;
      end else begin
         if (do_access && !bus_rw && offset == OFF_W'(REG_IRQ_EN)) irq_en_reg <= bus_wdata[1:0];
         irq_reg <= (irq_en_reg[0] && !rx_empty) || (irq_en_reg[1] && tx_empty);
      end
   end
`endif

   computie_bus_fifo #(
      .WIDTH      (BITWIDTH),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_tx_fifo (
      .clk       (comm_clock),
      .rst       (cb_reset),
      .push      (tx_push),
      .push_data (bus_wdata),
      .pop       (tx_ready),
      .head      (tx_data),
      .full      (tx_full),
      .empty     (tx_empty),
      .count     (tx_count)
   );

   computie_bus_fifo #(
      .WIDTH      (BITWIDTH),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_rx_fifo (
      .clk       (comm_clock),
      .rst       (cb_reset),
      .push      (rx_valid),
      .push_data (rx_data),
      .pop       (rx_pop),
      .head      (rx_head),
      .full      (rx_full),
      .empty     (rx_empty),
      .count     (rx_count)
   );

endmodule
